// File: rtl/board_reset_ctrl_if.sv
// Board reset controller pins: raw button in, clean reset/enable/event count out.
// The controller takes the master side; whatever drives the button takes the slave side.
interface board_reset_ctrl_if;
    logic       btn_n;
    logic       soc_rst_n;
    logic       btn_db_n;
    logic       clk_en;
    logic [7:0] rst_events;

    modport master (
        input  btn_n,
        output soc_rst_n,
        output btn_db_n,
        output clk_en,
        output rst_events
    );

    modport slave (
        output btn_n,
        input  soc_rst_n,
        input  btn_db_n,
        input  clk_en,
        input  rst_events
    );
endinterface

// File: rtl/board_reset_ctrl.sv
// Board reset controller: synchronises and debounces the reset button, holds the SoC
// in reset for a fixed time after release, counts presses and divides down a clock enable.
module board_reset_ctrl #(
    parameter int SYNC_STAGES     = 2,
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int HOLD_CYCLES     = 16,
    parameter int CLK_DIV         = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    board_reset_ctrl_if.master   bus
);

    localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int HOLD_W = $clog2(HOLD_CYCLES) + 1;
    localparam int DIV_W  = $clog2(CLK_DIV) + 1;

    localparam logic [CNT_W-1:0]  DB_LAST   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_CYCLES - 1);
    localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RUN     = 2'd1,
        PRESSED = 2'd2
    } state_e;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic                   btn_sync;
    logic [CNT_W-1:0]       db_cnt_q, db_cnt_d;
    logic                   btn_db_n_q, btn_db_n_d;

    state_e                 state_q, state_d;
    logic [HOLD_W-1:0]      hold_cnt_q, hold_cnt_d;
    logic                   soc_rst_n_q, soc_rst_n_d;
    logic [7:0]             rst_events_q, rst_events_d;

    logic [DIV_W-1:0]       div_q, div_d;
    logic                   clk_en_q, clk_en_d;

    // Only sync_q[0] ever samples the asynchronous button.
    assign btn_sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], bus.btn_n};
    end

    always_comb begin
        db_cnt_d   = '0;
        btn_db_n_d = btn_db_n_q;
        if (btn_sync != btn_db_n_q) begin
            if (db_cnt_q == DB_LAST) begin
                btn_db_n_d = btn_sync;
            end else begin
                db_cnt_d = db_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q     <= '1;
            db_cnt_q   <= '0;
            btn_db_n_q <= 1'b1;
        end else begin
            sync_q     <= sync_d;
            db_cnt_q   <= db_cnt_d;
            btn_db_n_q <= btn_db_n_d;
        end
    end

    // A low debounced level wins over hold completion, so a press still held
    // at the end of HOLD lands in PRESSED rather than briefly releasing the SoC.
    always_comb begin
        state_d      = state_q;
        hold_cnt_d   = hold_cnt_q;
        rst_events_d = rst_events_q;
        unique case (state_q)
            HOLD: begin
                if (!btn_db_n_q) begin
                    state_d = PRESSED;
                end else if (hold_cnt_q == HOLD_LAST) begin
                    state_d = RUN;
                end else begin
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                end
            end
            RUN: begin
                if (!btn_db_n_q) begin
                    state_d = PRESSED;
                    if (rst_events_q != 8'hFF) rst_events_d = rst_events_q + 8'd1;
                end
            end
            PRESSED: begin
                if (btn_db_n_q) begin
                    state_d    = HOLD;
                    hold_cnt_d = '0;
                end
            end
            default: begin
                state_d    = HOLD;
                hold_cnt_d = '0;
            end
        endcase
        soc_rst_n_d = (state_d == RUN);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= HOLD;
            hold_cnt_q   <= '0;
            soc_rst_n_q  <= 1'b0;
            rst_events_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_cnt_q   <= hold_cnt_d;
            soc_rst_n_q  <= soc_rst_n_d;
            rst_events_q <= rst_events_d;
        end
    end

    // Free-running divider; the enable is registered off the terminal count.
    always_comb begin
        div_d    = (div_q == DIV_LAST) ? '0 : div_q + DIV_W'(1);
        clk_en_d = (div_q == DIV_LAST);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q    <= '0;
            clk_en_q <= 1'b0;
        end else begin
            div_q    <= div_d;
            clk_en_q <= clk_en_d;
        end
    end

    assign bus.soc_rst_n  = soc_rst_n_q;
    assign bus.btn_db_n   = btn_db_n_q;
    assign bus.clk_en     = clk_en_q;
    assign bus.rst_events = rst_events_q;

endmodule

// File: tb/tb_board_reset_ctrl.sv
// Directed bench for board_reset_ctrl with short debounce/hold/divider parameters.
module tb_board_reset_ctrl;

    localparam int SYNC = 2;
    localparam int DEB  = 8;
    localparam int HOLD = 4;
    localparam int DIV  = 3;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    board_reset_ctrl_if bif ();

    board_reset_ctrl #(
        .SYNC_STAGES     (SYNC),
        .DEBOUNCE_CYCLES (DEB),
        .HOLD_CYCLES     (HOLD),
        .CLK_DIV         (DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bif.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        bif.btn_n = 1'b1;
        repeat (3) tick();
        checks++;
        if (bif.soc_rst_n !== 1'b0 || bif.btn_db_n !== 1'b1 || bif.clk_en !== 1'b0 || bif.rst_events !== 8'd0) begin
            errors++;
            $display("FAIL reset_values: soc=%b db=%b en=%b ev=%0d, want 0 1 0 0",
                     bif.soc_rst_n, bif.btn_db_n, bif.clk_en, bif.rst_events);
        end
        rst_n = 1'b1;
        for (int k = 1; k <= 9; k++) begin
            tick();
            checks++;
            if (bif.soc_rst_n !== (k >= 4)) begin
                errors++;
                $display("FAIL powerup_soc edge %0d: got %b want %b", k, bif.soc_rst_n, k >= 4);
            end
            checks++;
            if (bif.clk_en !== (k % 3 == 0)) begin
                errors++;
                $display("FAIL powerup_clk_en edge %0d: got %b want %b", k, bif.clk_en, k % 3 == 0);
            end
        end
        checks++;
        if (bif.rst_events !== 8'd0) begin
            errors++;
            $display("FAIL powerup_events: got %0d want 0", bif.rst_events);
        end
    endtask

    task automatic test_press();
        bif.btn_n = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (k == 9 || k == 10) begin
                checks++;
                if (bif.btn_db_n !== (k < 10)) begin
                    errors++;
                    $display("FAIL press_db edge %0d: got %b want %b", k, bif.btn_db_n, k < 10);
                end
            end
            if (k == 10 || k == 11) begin
                checks++;
                if (bif.soc_rst_n !== (k < 11)) begin
                    errors++;
                    $display("FAIL press_soc edge %0d: got %b want %b", k, bif.soc_rst_n, k < 11);
                end
                checks++;
                if (bif.rst_events !== ((k < 11) ? 8'd0 : 8'd1)) begin
                    errors++;
                    $display("FAIL press_events edge %0d: got %0d", k, bif.rst_events);
                end
            end
        end
        checks++;
        if (bif.rst_events !== 8'd1 || bif.soc_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL press_end: ev=%0d soc=%b want 1 0", bif.rst_events, bif.soc_rst_n);
        end
    endtask

    task automatic test_release();
        bif.btn_n = 1'b1;
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 9 || k == 10) begin
                checks++;
                if (bif.btn_db_n !== (k >= 10)) begin
                    errors++;
                    $display("FAIL release_db edge %0d: got %b want %b", k, bif.btn_db_n, k >= 10);
                end
            end
            if (k == 14 || k == 15 || k == 20) begin
                checks++;
                if (bif.soc_rst_n !== (k >= 15)) begin
                    errors++;
                    $display("FAIL release_soc edge %0d: got %b want %b", k, bif.soc_rst_n, k >= 15);
                end
            end
        end
        checks++;
        if (bif.rst_events !== 8'd1) begin
            errors++;
            $display("FAIL release_events: got %0d want 1", bif.rst_events);
        end
    endtask

    task automatic test_bounce();
        int runs [23] = '{1,2,3,4,5,6,7,7,6,5,4,3,2,1,7,7,3,5,2,6,4,7,3};
        logic lvl;
        int   bad;
        lvl = 1'b0;
        bad = 0;
        for (int r = 0; r < 23; r++) begin
            bif.btn_n = lvl;
            for (int c = 0; c < runs[r]; c++) begin
                tick();
                if (bif.btn_db_n !== 1'b1 || bif.soc_rst_n !== 1'b1) bad++;
            end
            lvl = ~lvl;
        end
        bif.btn_n = 1'b1;
        repeat (20) begin
            tick();
            if (bif.btn_db_n !== 1'b1 || bif.soc_rst_n !== 1'b1) bad++;
        end
        checks++;
        if (bad != 0) begin
            errors++;
            $display("FAIL bounce_levels: %0d cycles with db/soc not 1, want 0", bad);
        end
        checks++;
        if (bif.rst_events !== 8'd1) begin
            errors++;
            $display("FAIL bounce_events: got %0d want 1", bif.rst_events);
        end
    endtask

    task automatic test_divider();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            bif.btn_n = (k >= 2 && k <= 6) ? 1'b0 : 1'b1;
            tick();
            checks++;
            if (bif.clk_en !== (k % 3 == 0)) begin
                errors++;
                $display("FAIL divider edge %0d: got %b want %b", k, bif.clk_en, k % 3 == 0);
            end
        end
        bif.btn_n = 1'b1;
        repeat (10) tick();
        checks++;
        if (bif.soc_rst_n !== 1'b1 || bif.rst_events !== 8'd0) begin
            errors++;
            $display("FAIL divider_after: soc=%b ev=%0d want 1 0", bif.soc_rst_n, bif.rst_events);
        end
    endtask

    task automatic test_saturation();
        int exp_ev;
        exp_ev = 0;
        for (int p = 1; p <= 260; p++) begin
            bif.btn_n = 1'b0;
            repeat (15) tick();
            if (exp_ev < 255) exp_ev++;
            checks++;
            if (bif.rst_events !== 8'(exp_ev) || bif.soc_rst_n !== 1'b0) begin
                errors++;
                $display("FAIL saturation press %0d: ev=%0d soc=%b want %0d 0",
                         p, bif.rst_events, bif.soc_rst_n, exp_ev);
            end
            bif.btn_n = 1'b1;
            repeat (20) tick();
        end
        checks++;
        if (bif.rst_events !== 8'd255 || bif.soc_rst_n !== 1'b1) begin
            errors++;
            $display("FAIL saturation_end: ev=%0d soc=%b want 255 1", bif.rst_events, bif.soc_rst_n);
        end
    endtask

    task automatic test_midreset();
        bif.btn_n = 1'b0;
        repeat (15) tick();
        checks++;
        if (bif.soc_rst_n !== 1'b0 || bif.btn_db_n !== 1'b0) begin
            errors++;
            $display("FAIL midreset_pressed: soc=%b db=%b want 0 0", bif.soc_rst_n, bif.btn_db_n);
        end
        rst_n = 1'b0;
        tick();
        checks++;
        if (bif.soc_rst_n !== 1'b0 || bif.btn_db_n !== 1'b1 || bif.clk_en !== 1'b0 || bif.rst_events !== 8'd0) begin
            errors++;
            $display("FAIL midreset_values: soc=%b db=%b en=%b ev=%0d, want 0 1 0 0",
                     bif.soc_rst_n, bif.btn_db_n, bif.clk_en, bif.rst_events);
        end
        bif.btn_n = 1'b1;
        rst_n     = 1'b1;
        repeat (3) tick();
        checks++;
        if (bif.soc_rst_n !== 1'b0) begin
            errors++;
            $display("FAIL midreset_hold: got %b want 0", bif.soc_rst_n);
        end
        tick();
        checks++;
        if (bif.soc_rst_n !== 1'b1 || bif.rst_events !== 8'd0) begin
            errors++;
            $display("FAIL midreset_run: soc=%b ev=%0d want 1 0", bif.soc_rst_n, bif.rst_events);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bif.btn_n = 1'b1;
        test_reset();
        test_press();
        test_release();
        test_bounce();
        test_divider();
        test_saturation();
        test_midreset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
